// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-master arbiter in front of a single shared memory port. The
// instruction-fetch master (read only) and the load/store master compete for
// the port, with at most one transaction in flight.
//
// Data requests normally win. After STARVE_MAX consecutive data wins while
// fetch was also waiting, fetch is given the next grant.
//
// Each transaction runs IDLE -> BUSY_I/BUSY_D -> RESP -> IDLE:
//   - the grant is combinational in the IDLE cycle;
//   - the command is registered and held on the memory port while BUSY;
//   - read data is captured on mem_ready;
//   - the owner's rvalid pulses for one cycle in RESP.
//
// Optional build macro:
//   MEM_ARB_TIMEOUT_EN  enables a response watchdog. If a BUSY phase lasts
//                       TIMEOUT cycles without mem_ready, the transaction
//                       completes with all-ones data and the sticky err flag
//                       is set until reset. Without the macro, BUSY waits
//                       forever and err is tied low.
//
// Parameters:
//   AW          address width
//   DW          data width (byte enables are DW/8 wide)
//   STARVE_MAX  consecutive data wins tolerated while fetch waits
//   TIMEOUT     watchdog limit in cycles (only with MEM_ARB_TIMEOUT_EN)
//
// Ports:
//   clk, rst                                 clock, synchronous active-low reset
//   i_req, i_addr                            fetch request and address
//   i_gnt, i_rvalid, i_rdata                 fetch accept, completion pulse, data
//   d_req, d_we, d_addr, d_wdata, d_be       load/store request
//   d_gnt, d_rvalid, d_rdata                 data accept, completion pulse, data
//   mem_req, mem_we, mem_addr, mem_wdata,
//   mem_be                                   command to the shared memory port
//   mem_ready, mem_rdata                     memory completion strobe and data
//   busy                                     high whenever not IDLE
//   err                                      sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,

    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,

    output logic            busy,
    output logic            err
);

    localparam int BW = DW / 8;
    localparam int SW = $clog2(STARVE_MAX + 1);

    if (STARVE_MAX < 1 || TIMEOUT < 1 || (DW % 8) != 0) begin : g_param_check
        $error("mem_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [SW-1:0]   starve_cnt;
    logic            owner_d;      // 1 when the load/store side owns the transaction
    logic            starve_hit;
    logic            win_i;
    logic            win_d;
    logic            in_busy;
    logic            timeout_hit;

    // -----------------------------------------------------------------------
    // Arbitration.
    // Grants are suppressed while reset is asserted, so every output is low
    // for the whole time rst is held at 0.
    // -----------------------------------------------------------------------
    always_comb begin
        starve_hit = (starve_cnt == SW'(STARVE_MAX));
        win_d      = rst && (state == IDLE) && d_req && !(i_req && starve_hit);
        win_i      = rst && (state == IDLE) && i_req && !win_d;
        in_busy    = (state == BUSY_I) || (state == BUSY_D);
    end

    // -----------------------------------------------------------------------
    // Response watchdog (optional).
    // The counter is zeroed while IDLE, which covers every BUSY entry, so it
    // reads 0 in the first BUSY cycle. timeout_hit fires in the cycle the
    // count equals TIMEOUT; RESP follows one cycle later.
    // -----------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;

    assign timeout_hit = in_busy && !mem_ready && (tmo_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (!in_busy) begin
                tmo_cnt <= '0;
            end else if (!timeout_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        mem_req   = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (win_d) begin
                    d_gnt     = 1'b1;
                    state_nxt = BUSY_D;
                end else if (win_i) begin
                    i_gnt     = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                mem_req = 1'b1;
                if (mem_ready || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                i_rvalid  = !owner_d;
                d_rvalid  = owner_d;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Command latch, starvation counter and response capture.
    // Read data lands directly in the owner's rdata register on completion,
    // so it is valid during the RESP pulse and holds until the next
    // completion for that master. A timed-out transaction returns all ones.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (win_d) begin
                owner_d   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
                if (!i_req) begin
                    starve_cnt <= '0;
                end else if (!starve_hit) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (win_i) begin
                owner_d    <= 1'b0;
                mem_we     <= 1'b0;
                mem_addr   <= i_addr;
                mem_wdata  <= '0;
                mem_be     <= {BW{1'b1}};
                starve_cnt <= '0;
            end

            if (in_busy && mem_ready) begin
                if (owner_d) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end else if (timeout_hit) begin
                if (owner_d) begin
                    d_rdata <= {DW{1'b1}};
                end else begin
                    i_rdata <= {DW{1'b1}};
                end
            end
        end
    end

endmodule
